// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer: SKID=1 two-entry skid buffer, SKID=0 single register; optional stall counter via PIPE_STAGE_STALL_CNT_EN.
// Latency: 1 cycle from an accepted beat to dn_valid when the stage is empty or draining.
// Backpressure: SKID=1 up_ready is decoded from state only; SKID=0 up_ready = dn_ready | ~dn_valid.
module pipe_stage_buffer #(
    parameter int DATA_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    input  logic              dn_ready,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    logic up_xfer;
    logic dn_xfer;

    assign up_xfer = up_valid && up_ready;
    assign dn_xfer = dn_valid && dn_ready;

    if (SKID != 0) begin : g_skid
        state_t            state;
        state_t            state_nxt;
        logic [DATA_W-1:0] main_q;
        logic [DATA_W-1:0] main_nxt;
        logic [DATA_W-1:0] skid_q;
        logic [DATA_W-1:0] skid_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= ST_EMPTY;
                main_q <= '0;
                skid_q <= '0;
            end else begin
                state  <= state_nxt;
                main_q <= main_nxt;
                skid_q <= skid_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            main_nxt  = main_q;
            skid_nxt  = skid_q;
            case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state_nxt = ST_FULL;
                        main_nxt  = up_data;
                    end
                end
                ST_FULL: begin
                    if (up_xfer && dn_xfer) begin
                        main_nxt = up_data;
                    end else if (dn_xfer) begin
                        state_nxt = ST_EMPTY;
                    end else if (up_xfer) begin
                        state_nxt = ST_SKID;
                        skid_nxt  = up_data;
                    end
                end
                ST_SKID: begin
                    if (dn_xfer) begin
                        state_nxt = ST_FULL;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
            // Payload may still load on flush; only the occupancy is killed.
            if (flush) begin
                state_nxt = ST_EMPTY;
            end
        end

        assign up_ready = (state != ST_SKID);
        assign dn_valid = (state != ST_EMPTY);
        assign dn_data  = main_q;
    end else begin : g_reg
        logic              valid_q;
        logic [DATA_W-1:0] data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                if (up_xfer) begin
                    data_q <= up_data;
                end
                if (flush) begin
                    valid_q <= 1'b0;
                end else if (up_xfer) begin
                    valid_q <= 1'b1;
                end else if (dn_xfer) begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign up_ready = dn_ready || !valid_q;
        assign dn_valid = valid_q;
        assign dn_data  = data_q;
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if (dn_valid && !dn_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Drives one stimulus stream into a SKID=0 and a SKID=1 instance; each is scored against a queue-based occupancy model.
module tb_pipe_stage_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic [15:0] up_data;
    logic        dn_ready;

    logic        up_ready_s [2];
    logic        dn_valid_s [2];
    logic [15:0] dn_data_s  [2];
    logic [15:0] stall_s    [2];

    int total = 0;
    int bad   = 0;

    pipe_stage_buffer #(.DATA_W(16), .SKID(0)) dut_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (up_valid),
        .up_data  (up_data),
        .up_ready (up_ready_s[0]),
        .dn_valid (dn_valid_s[0]),
        .dn_data  (dn_data_s[0]),
        .dn_ready (dn_ready),
        .stall_cnt(stall_s[0])
    );

    pipe_stage_buffer #(.DATA_W(16), .SKID(1)) dut_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (up_valid),
        .up_data  (up_data),
        .up_ready (up_ready_s[1]),
        .dn_valid (dn_valid_s[1]),
        .dn_data  (dn_data_s[1]),
        .dn_ready (dn_ready),
        .stall_cnt(stall_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        up_valid = v;
        up_data  = d;
        dn_ready = r;
        flush    = f;
    endtask

    // Model: an ordered queue of accepted beats; capacity 2 (skid) or 1 (register).
    for (genvar k = 0; k < 2; k++) begin : g_mon
        logic [15:0] q[$];
        int unsigned exp_stall;
        int          sz;
        logic        exp_rdy;

        initial exp_stall = 0;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                exp_stall = 0;
            end else begin
                sz      = q.size();
                exp_rdy = (k == 1) ? (sz < 2) : (dn_ready || sz == 0);
                check($sformatf("dn_valid[%0d]", k), {31'd0, dn_valid_s[k]}, {31'd0, sz > 0});
                if (sz > 0) begin
                    check($sformatf("dn_data[%0d]", k), {16'd0, dn_data_s[k]}, {16'd0, q[0]});
                end
                check($sformatf("up_ready[%0d]", k), {31'd0, up_ready_s[k]}, {31'd0, exp_rdy});
                check($sformatf("stall_cnt[%0d]", k), {16'd0, stall_s[k]}, exp_stall);

                if (sz > 0 && dn_ready) begin
                    void'(q.pop_front());
                end
                if (flush) begin
                    q.delete();
                end else if (up_valid && exp_rdy) begin
                    q.push_back(up_data);
                end
`ifdef PIPE_STAGE_STALL_CNT_EN
                if (sz > 0 && !dn_ready && exp_stall < 32'hFFFF) begin
                    exp_stall = exp_stall + 1;
                end
`endif
            end
        end
    end

    initial begin
        logic [15:0] exp_sat;
`ifdef PIPE_STAGE_STALL_CNT_EN
        exp_sat = 16'hFFFF;
`else
        exp_sat = 16'h0000;
`endif
        rst_n    = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b0;
        up_data  = 16'h0;
        dn_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_dn_valid[%0d]", k), {31'd0, dn_valid_s[k]}, 32'd0);
            check($sformatf("rst_up_ready[%0d]", k), {31'd0, up_ready_s[k]}, 32'd1);
            check($sformatf("rst_dn_data[%0d]", k), {16'd0, dn_data_s[k]}, 32'd0);
            check($sformatf("rst_stall[%0d]", k), {16'd0, stall_s[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back stream with downstream always ready.
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Fill the skid entry under backpressure, then drain.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Flush while full with a beat offered in the same cycle.
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        drive(1'b1, 16'hCCCC, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Single-register replacement while draining.
        drive(1'b1, 16'h5555, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 16'h6666, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Long stall until the counter saturates, then an asynchronous reset mid-cycle.
        drive(1'b1, 16'h7777, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #2;
        check("sat_dn_valid", {31'd0, dn_valid_s[1]}, 32'd1);
        check("sat_stall_skid", {16'd0, stall_s[1]}, {16'd0, exp_sat});
        check("sat_stall_reg", {16'd0, stall_s[0]}, {16'd0, exp_sat});
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("arst_dn_valid[%0d]", k), {31'd0, dn_valid_s[k]}, 32'd0);
            check($sformatf("arst_stall[%0d]", k), {16'd0, stall_s[k]}, 32'd0);
        end
        check("arst_up_ready", {31'd0, up_ready_s[1]}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 16'h8888, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the payload width in bits (legal 1..256).
REQ-002 The block SHALL have parameter SKID, default 1: 1 means a two-entry skid buffer with registered up_ready; 0 means a single-entry register with combinational up_ready.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  kill all held beats (branch mispredict / squash).
REQ-006 up_valid  input  1  upstream stage presents a beat.
REQ-007 up_data  input  DATA_W  upstream payload (PC, control word, ALU out, IR, dest, ...).
REQ-008 up_ready  output  1  block accepts a beat this cycle.
REQ-009 dn_valid  output  1  block presents a beat downstream.
REQ-010 dn_data  output  DATA_W  downstream payload, driven directly from a flop.
REQ-011 dn_ready  input  1  downstream stage accepts the beat this cycle.
REQ-012 stall_cnt  output  16  count of cycles with dn_valid=1 and dn_ready=0.

Function
REQ-013 The block SHALL complete an upstream transfer when up_valid and up_ready are both 1, and a downstream transfer when dn_valid and dn_ready are both 1.
REQ-014 The block SHALL have a latency of exactly 1 cycle from an accepted upstream beat to dn_valid, when the block was empty or draining in that cycle.
REQ-015 The block SHALL deliver beats in acceptance order, never duplicating or dropping one except on flush.
REQ-016 With SKID=1, states SHALL be EMPTY (no beat), FULL (main holds a beat), and SKID (main and skid both hold beats).
REQ-017 EMPTY->FULL on an upstream transfer; FULL->EMPTY on a downstream transfer without an upstream transfer; FULL->SKID on an upstream transfer without a downstream transfer (the new beat goes to skid); SKID->FULL on a downstream transfer (skid moves to main); all other cases hold state.
REQ-018 With SKID=1, up_ready SHALL equal the registered condition (state != SKID), with no combinational path from dn_ready.
REQ-019 With SKID=0, up_ready SHALL equal dn_ready OR NOT dn_valid, and there SHALL be no skid storage or SKID state.
REQ-020 dn_data SHALL hold stable while dn_valid=1 and dn_ready=0.
REQ-021 In FULL with simultaneous upstream and downstream transfers, main SHALL load up_data and the state SHALL stay FULL.
REQ-022 Flush SHALL dominate: in a cycle with flush=1, the next state SHALL be EMPTY regardless of valid/ready, and any beat accepted that cycle SHALL be discarded.
REQ-023 Payload flops MAY retain stale data when invalid; only valid bits are cleared by flush.
REQ-024 stall_cnt SHALL increment by 1 per stall cycle, saturate at 16'hFFFF, and be unaffected by flush.

Reset
REQ-025 While rst_n=0, state SHALL be EMPTY, dn_valid=0, stall_cnt=0, and up_ready=1 (SKID=1), all immediately and asynchronously.
REQ-026 dn_data SHALL reset to all zeros.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk; reset asserted mid-transfer SHALL lose all beats with no partial output.

Configuration
REQ-028 Macro PIPE_STAGE_STALL_CNT_EN: when defined, stall_cnt SHALL behave per REQ-024.
REQ-029 When PIPE_STAGE_STALL_CNT_EN is undefined, stall_cnt SHALL be constant 0 and no counter flops SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-030 SKID=1, dn_ready=1, stream 16'h0001..16'h0004 on consecutive cycles -> dn_data 0001..0004 one cycle later each, up_ready constantly 1.
REQ-031 SKID=1, dn_ready=0, push A=16'hAAAA then B=16'hBBBB -> dn_data=AAAA, up_ready=0 the cycle after B; raise dn_ready -> AAAA then BBBB delivered, up_ready returns to 1.
REQ-032 SKID state plus flush=1 with up_valid=1 (C=16'hCCCC) -> next cycle dn_valid=0, up_ready=1, C never appears downstream.
REQ-033 SKID=0, dn_valid=1, dn_ready=0 -> up_ready=0 in the same cycle; dn_ready=1 with up_valid=1 -> replacement beat presented next cycle.
REQ-034 Macro defined, hold dn_valid=1 and dn_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; pulse rst_n=0 mid-stall -> dn_valid=0 and stall_cnt=0 immediately.
REQ-035 Macro undefined, repeat REQ-034 stimulus -> stall_cnt=0 throughout, data behaviour identical.
